// File: rtl/display_scanner.sv
// Multiplexed 4-digit 7-segment scanner with per-frame BCD shadow latch,
// leading-zero suppression and anti-ghost blanking at the start of each slot.
module display_scanner #(
  parameter int DIV          = 50000,
  parameter int BLANK_CYC    = 64,
  parameter bit COMMON_ANODE = 1'b1,
  parameter bit LZ_BLANK     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data_in,
  output logic        next_data,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic [1:0]  frame_sel
);

  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;

  localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] P_PRE  = PW'(DIV - 2);
  localparam logic [PW-1:0] P_BLK  = PW'(BLANK_CYC);

  localparam logic [3:0] AN_OFF  = COMMON_ANODE ? 4'hF : 4'h0;
  localparam logic [6:0] SEG_OFF = COMMON_ANODE ? 7'h7F : 7'h00;

  logic [PW-1:0] r_presc;
  logic [1:0]    r_frame_sel;
  logic [15:0]   r_shadow;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;

  logic          w_last;
  logic          w_boundary;
  logic [3:0]    w_nib;
  logic [3:0]    w_zero_up;
  logic          w_dark;
  logic [3:0]    w_an;
  logic [6:0]    w_seg;
  logic [6:0]    w_glyph;

  // segment order {g,f,e,d,c,b,a}, active-high
  function automatic logic [6:0] f_decode(input logic [3:0] nib);
    logic [6:0] s;
    s = 7'b1000000;
    case (nib)
      4'd0: s = 7'b0111111;
      4'd1: s = 7'b0000110;
      4'd2: s = 7'b1011011;
      4'd3: s = 7'b1001111;
      4'd4: s = 7'b1100110;
      4'd5: s = 7'b1101101;
      4'd6: s = 7'b1111101;
      4'd7: s = 7'b0000111;
      4'd8: s = 7'b1111111;
      4'd9: s = 7'b1101111;
      default: s = 7'b1000000;
    endcase
    return s;
  endfunction

  always_comb begin
    w_last     = (r_presc == P_LAST);
    w_boundary = w_last && (r_frame_sel == 2'd3);
    w_nib      = 4'(r_shadow >> {r_frame_sel, 2'b00});
    w_glyph    = f_decode(w_nib);
  end

  // w_zero_up[k]: nibble k and every nibble above it are zero
  always_comb begin
    w_zero_up    = 4'b0000;
    w_zero_up[3] = (r_shadow[15:12] == 4'd0);
    w_zero_up[2] = w_zero_up[3] && (r_shadow[11:8] == 4'd0);
    w_zero_up[1] = w_zero_up[2] && (r_shadow[7:4] == 4'd0);
    w_zero_up[0] = 1'b0;
    w_dark       = LZ_BLANK && w_zero_up[r_frame_sel];
  end

  always_comb begin
    w_an  = 4'b0000;
    w_seg = 7'b0000000;
    if (!(r_presc < P_BLK) && !w_dark) begin
      w_an  = 4'b0001 << r_frame_sel;
      w_seg = w_glyph;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_presc     <= '0;
      r_frame_sel <= 2'd0;
      r_shadow    <= 16'h0000;
      r_an        <= AN_OFF;
      r_seg       <= SEG_OFF;
    end else begin
      r_presc <= w_last ? '0 : r_presc + PW'(1);
      if (w_last)
        r_frame_sel <= r_frame_sel + 2'd1;
      if (w_boundary)
        r_shadow <= data_in;
      r_an  <= w_an ^ AN_OFF;
      r_seg <= w_seg ^ SEG_OFF;
    end
  end

  assign next_data = (r_presc == P_PRE) && (r_frame_sel == 2'd3);
  assign seg       = r_seg;
  assign an        = r_an;
  assign frame_sel = r_frame_sel;

endmodule

// File: tb/tb_display_scanner.sv
// Directed bench for display_scanner: per-frame glyph tables, reset
// mid-scan, and data change mid-frame.
module tb_display_scanner;

  logic        clk;
  logic        rst;
  logic [15:0] data_in;
  logic        next_data;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [1:0]  frame_sel;

  int n_chk;
  int n_fail;

  display_scanner #(
    .DIV(8),
    .BLANK_CYC(2),
    .COMMON_ANODE(1'b1),
    .LZ_BLANK(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .data_in(data_in),
    .next_data(next_data),
    .seg(seg),
    .an(an),
    .frame_sel(frame_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]     data;
    logic [3:0][6:0] seg;
    logic [3:0][3:0] an;
  } vec_t;

  vec_t tv[9];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pulse();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      step();
      if (next_data) begin
        seen = 1'b1;
        break;
      end
    end
    check("next_data_timeout", int'(seen), 1);
  endtask

  // entry: regs at presc=0, frame_sel=0 with the word of v already latched
  task automatic run_frame(input vec_t v, input int chg_k, input logic [15:0] chg_d);
    int p;
    int s;
    for (int k = 1; k <= 32; k++) begin
      if (k == chg_k)
        data_in = chg_d;
      step();
      p = (k - 1) % 8;
      s = (k - 1) / 8;
      check("frame_sel", int'(frame_sel), (k / 8) % 4);
      check("next_data", int'(next_data), int'(k == 30));
      if (p < 2) begin
        check("an_blank", int'(an), 'hF);
        check("seg_blank", int'(seg), 'h7F);
      end else begin
        check("an_slot", int'(an), int'(v.an[s]));
        if (v.an[s] != 4'hF)
          check("seg_slot", int'(seg), int'(v.seg[s]));
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    data_in = v.data;
    wait_pulse();
    step();
    step();
    run_frame(v, -1, 16'h0);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    // digits listed d3,d2,d1,d0; blank digit has an=F
    tv[0] = '{16'h1234, {7'h79, 7'h24, 7'h30, 7'h19}, {4'h7, 4'hB, 4'hD, 4'hE}};
    tv[1] = '{16'h0007, {7'h7F, 7'h7F, 7'h7F, 7'h78}, {4'hF, 4'hF, 4'hF, 4'hE}};
    tv[2] = '{16'h0000, {7'h7F, 7'h7F, 7'h7F, 7'h40}, {4'hF, 4'hF, 4'hF, 4'hE}};
    tv[3] = '{16'h1005, {7'h79, 7'h40, 7'h40, 7'h12}, {4'h7, 4'hB, 4'hD, 4'hE}};
    tv[4] = '{16'h00A3, {7'h7F, 7'h7F, 7'h3F, 7'h30}, {4'hF, 4'hF, 4'hD, 4'hE}};
    tv[5] = '{16'h9876, {7'h10, 7'h00, 7'h78, 7'h02}, {4'h7, 4'hB, 4'hD, 4'hE}};
    tv[6] = '{16'h0F00, {7'h7F, 7'h3F, 7'h40, 7'h40}, {4'hF, 4'hB, 4'hD, 4'hE}};
    tv[7] = '{16'h1111, {7'h79, 7'h79, 7'h79, 7'h79}, {4'h7, 4'hB, 4'hD, 4'hE}};
    tv[8] = '{16'h2222, {7'h24, 7'h24, 7'h24, 7'h24}, {4'h7, 4'hB, 4'hD, 4'hE}};

    rst     = 1'b0;
    data_in = 16'h0000;
    #1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_an", int'(an), 'hF);
      check("rst_seg", int'(seg), 'h7F);
      check("rst_nd", int'(next_data), 0);
      check("rst_fs", int'(frame_sel), 0);
    end
    rst = 1'b1;
    run_frame(tv[2], -1, 16'h0);

    for (int i = 0; i < 7; i++)
      run_vec(tv[i]);

    // word change mid-frame only shows from the following frame
    run_vec(tv[7]);
    run_frame(tv[7], 11, 16'h2222);
    run_frame(tv[8], -1, 16'h0);

    // reset mid-slot, then the scan restarts from presc=0 with shadow cleared
    for (int i = 0; i < 13; i++)
      step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("mid_rst_an", int'(an), 'hF);
      check("mid_rst_seg", int'(seg), 'h7F);
      check("mid_rst_nd", int'(next_data), 0);
      check("mid_rst_fs", int'(frame_sel), 0);
    end
    rst = 1'b1;
    run_frame(tv[2], -1, 16'h0);
    run_vec(tv[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
